// File: rtl/sar_pkg.sv
// sar_pkg: shared types, constants and helpers for the SAR controller.
// Optional feature macro: SAR_COMP_SYNC_EN (2-flop comparator synchronizer).
package sar_pkg;

  // Controller states
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    TRIAL = 1'b1
  } sar_state_t;

  // Extra decision latency contributed by the comparator synchronizer
`ifdef SAR_COMP_SYNC_EN
  localparam int unsigned SAR_SYNC_LAT = 2;
`else
  localparam int unsigned SAR_SYNC_LAT = 0;
`endif

  // $clog2 with a floor of 1 so single-value counters still get a bit
  function automatic int unsigned sar_clog2_min1(input int unsigned v);
    int unsigned w;
    w = $clog2(v);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sar_sync.sv
// sar_sync: 2-flop synchronizer for the asynchronous comparator decision.
// Only instantiated when SAR_COMP_SYNC_EN is defined.
module sar_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the async input; both stages reset to 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/sar_ctrl.sv
// sar_ctrl: successive-approximation controller driving a threshold DAC and
// consuming a 1-bit comparator decision, MSB first, SETTLE_EFF cycles per bit.
// Optional feature macro: SAR_COMP_SYNC_EN (comp_in via 2-flop synchronizer).
module sar_ctrl
  import sar_pkg::*;
#(
  parameter int unsigned N      = 8,
  parameter int unsigned SETTLE = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic         comp_in,
  output logic [N-1:0] dac_code,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int unsigned SETTLE_EFF = SETTLE + SAR_SYNC_LAT;
  localparam int unsigned IW         = sar_clog2_min1(N);
  localparam int unsigned CW         = sar_clog2_min1(SETTLE_EFF);

  sar_state_t      r_state;
  logic [N-1:0]    r_dac_code;
  logic [N-1:0]    r_result;
  logic            r_busy;
  logic            r_done;
  logic [IW-1:0]   r_bit_idx;
  logic [CW-1:0]   r_cnt;

  sar_state_t      w_state_nxt;
  logic [N-1:0]    w_dac_nxt;
  logic [N-1:0]    w_result_nxt;
  logic            w_busy_nxt;
  logic            w_done_nxt;
  logic [IW-1:0]   w_idx_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [N-1:0]    w_code;
  logic [IW-1:0]   w_idx_m1;
  logic            w_c;

`ifdef SAR_COMP_SYNC_EN
  sar_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (comp_in),
    .o_sync  (w_c)
  );
`else
  assign w_c = comp_in;
`endif

  assign w_idx_m1 = r_bit_idx - IW'(1);

  // Code after the current decision: resolve this bit, tentatively set the next
  always_comb begin
    w_code = r_dac_code;
    w_code[r_bit_idx] = w_c;
    if (r_bit_idx != '0) begin
      w_code[w_idx_m1] = 1'b1;
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    w_state_nxt  = r_state;
    w_dac_nxt    = r_dac_code;
    w_result_nxt = r_result;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_idx_nxt    = r_bit_idx;
    w_cnt_nxt    = r_cnt;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_dac_nxt   = {1'b1, {(N-1){1'b0}}};
          w_idx_nxt   = IW'(N - 1);
          w_cnt_nxt   = CW'(SETTLE_EFF - 1);
          w_busy_nxt  = 1'b1;
          w_state_nxt = TRIAL;
        end
      end
      TRIAL: begin
        if (abort) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else if (r_bit_idx != '0) begin
          w_dac_nxt = w_code;
          w_idx_nxt = w_idx_m1;
          w_cnt_nxt = CW'(SETTLE_EFF - 1);
        end else begin
          w_dac_nxt    = w_code;
          w_result_nxt = w_code;
          w_done_nxt   = 1'b1;
          w_busy_nxt   = 1'b0;
          w_state_nxt  = IDLE;
        end
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_dac_code <= '0;
      r_result   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bit_idx  <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_dac_code <= w_dac_nxt;
      r_result   <= w_result_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_bit_idx  <= w_idx_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  assign dac_code = r_dac_code;
  assign result   = r_result;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_sar_ctrl.sv
// tb_sar_ctrl: directed self-checking bench for sar_ctrl (N=8, SETTLE=2).
module tb_sar_ctrl;
  import sar_pkg::*;

  localparam int SE  = 2 + int'(SAR_SYNC_LAT);
  localparam int LAT = 8 * SE;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       comp_in;
  logic [7:0] dac_code;
  logic       busy;
  logic       done;
  logic [7:0] result;

  logic [7:0] vin;
  int         mode;
  int         n_checks;
  int         n_errors;
  logic [7:0] seq5a [8];

  sar_ctrl #(.N(8), .SETTLE(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .comp_in  (comp_in),
    .dac_code (dac_code),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator model: ideal, forced high, or forced low
  always_comb begin
    comp_in = 1'b0;
    if (mode == 1)      comp_in = 1'b1;
    else if (mode == 2) comp_in = 1'b0;
    else                comp_in = (vin >= dac_code);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge; returns at the negedge after the start edge
  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done, counting edges since the start edge
  task automatic wait_done(input string tag, input bit chk_seq, input int k_init);
    int k;
    bit hit;
    k   = k_init;
    hit = 1'b0;
    while (k <= LAT + 4) begin
      if (done) begin
        hit = 1'b1;
        break;
      end
      if (chk_seq && (k % SE == 0) && (k / SE < 8))
        check("dac_seq", 32'(dac_code), 32'(seq5a[k / SE]));
      @(negedge clk);
      k++;
    end
    check({tag, "_lat"}, hit ? 32'(k) : 32'hFFFF, 32'(LAT));
    check({tag, "_busy_at_done"}, 32'(busy), 32'h0);
  endtask

  initial begin
    int ndone;
    seq5a = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A, 8'h5B};
    n_checks = 0;
    n_errors = 0;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    mode  = 0;
    vin   = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_dac",    32'(dac_code), 32'h0);
    check("rst_result", 32'(result),   32'h0);
    check("rst_busy",   32'(busy),     32'h0);
    check("rst_done",   32'(done),     32'h0);
    rst = 1'b0;

    // Ideal comparator, vin=0x5A, with trial sequence
    vin = 8'h5A;
    do_start();
    check("ideal_busy", 32'(busy), 32'h1);
    wait_done("ideal", 1'b1, 0);
    check("ideal_result", 32'(result), 32'h5A);
    check("ideal_dac_final", 32'(dac_code), 32'h5A);
    @(negedge clk);
    check("ideal_done_width", 32'(done), 32'h0);

    // Comparator stuck high / low
    mode = 1;
    do_start();
    wait_done("all1", 1'b0, 0);
    check("all1_result", 32'(result), 32'hFF);
    mode = 2;
    do_start();
    wait_done("all0", 1'b0, 0);
    check("all0_result", 32'(result), 32'h00);
    mode = 0;

    // start re-asserted while busy is ignored
    vin = 8'h3C;
    do_start();
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done("busy_start", 1'b0, 3);
    check("busy_start_result", 32'(result), 32'h3C);

    // Back-to-back: start during the done cycle
    vin = 8'h5A;
    do_start();
    wait_done("b2b_first", 1'b0, 0);
    check("b2b_first_result", 32'(result), 32'h5A);
    vin   = 8'hC3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_done_width", 32'(done), 32'h0);
    check("b2b_busy", 32'(busy), 32'h1);
    wait_done("b2b_second", 1'b0, 0);
    check("b2b_second_result", 32'(result), 32'hC3);

    // Abort mid-conversion after a result of 0x33
    vin = 8'h33;
    do_start();
    wait_done("pre_abort", 1'b0, 0);
    check("pre_abort_result", 32'(result), 32'h33);
    vin = 8'hAA;
    do_start();
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_result", 32'(result), 32'h33);
    ndone = 0;
    for (int i = 0; i < 2 * LAT; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'h0);
    check("abort_result_hold", 32'(result), 32'h33);

    // Reset pulsed mid-conversion
    vin = 8'h77;
    do_start();
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_dac",    32'(dac_code), 32'h0);
    check("midrst_result", 32'(result),   32'h0);
    check("midrst_busy",   32'(busy),     32'h0);
    check("midrst_done",   32'(done),     32'h0);
    @(negedge clk);
    rst = 1'b0;
    vin = 8'h5A;
    do_start();
    wait_done("post_rst", 1'b1, 0);
    check("post_rst_result", 32'(result), 32'h5A);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
